// File: rtl/fpu.sv
// Two-stage binary32 add/sub/mul/div unit with truncating rounding.
// Optional divider is built when FPU_DIV_EN is defined.
module fpu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  opcode,
    output logic [31:0] O
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [1:0]  r_op;
    logic [31:0] r_o;
    logic [31:0] w_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a  <= '0;
            r_b  <= '0;
            r_op <= '0;
            r_o  <= '0;
        end else begin
            r_a  <= A;
            r_b  <= B;
            r_op <= opcode;
            r_o  <= w_res;
        end
    end

    assign O = r_o;

    // Saturate to inf above the range, flush to signed zero below it.
    function automatic logic [31:0] pack(
        input logic              s,
        input logic signed [10:0] e,
        input logic [22:0]       f
    );
        if (e >= 11'sd255)
            return {s, 8'hFF, 23'd0};
        else if (e <= 11'sd0)
            return {s, 31'd0};
        else
            return {s, e[7:0], f};
    endfunction

    function automatic logic [5:0] lzc49(input logic [48:0] v);
        logic [5:0] n;
        n = 6'd49;
        for (int i = 0; i < 49; i++)
            if (v[i]) n = 6'(48 - i);
        return n;
    endfunction

    logic        w_sa, w_sb;
    logic [7:0]  w_ea, w_eb;
    logic        w_za, w_zb, w_ia, w_ib, w_na, w_nb;
    logic [23:0] w_ma, w_mb;

    // Subnormals and zeros both collapse to a zero significand.
    always_comb begin
        w_sa = r_a[31];
        w_sb = r_b[31];
        w_ea = r_a[30:23];
        w_eb = r_b[30:23];
        w_za = (w_ea == 8'd0);
        w_zb = (w_eb == 8'd0);
        w_ia = (w_ea == 8'hFF) && (r_a[22:0] == 23'd0);
        w_ib = (w_eb == 8'hFF) && (r_b[22:0] == 23'd0);
        w_na = (w_ea == 8'hFF) && (r_a[22:0] != 23'd0);
        w_nb = (w_eb == 8'hFF) && (r_b[22:0] != 23'd0);
        w_ma = w_za ? 24'd0 : {1'b1, r_a[22:0]};
        w_mb = w_zb ? 24'd0 : {1'b1, r_b[22:0]};
    end

    logic              w_sbe, w_swap, w_sl;
    logic [7:0]        w_el, w_es, w_d;
    logic [23:0]       w_ml, w_ms;
    logic [48:0]       w_wl, w_ws, w_sum, w_norm;
    logic [5:0]        w_lz;
    logic signed [10:0] w_eadd;
    logic [31:0]       w_add;

    always_comb begin
        w_sbe  = w_sb ^ (r_op == 2'b01);
        w_swap = {w_eb, w_mb} > {w_ea, w_ma};
        w_el   = w_swap ? w_eb : w_ea;
        w_es   = w_swap ? w_ea : w_eb;
        w_ml   = w_swap ? w_mb : w_ma;
        w_ms   = w_swap ? w_ma : w_mb;
        w_sl   = w_swap ? w_sbe : w_sa;
        w_d    = w_el - w_es;
        w_wl   = {1'b0, w_ml, 24'd0};
        w_ws   = {1'b0, w_ms, 24'd0} >> w_d;
        w_sum  = (w_sa ^ w_sbe) ? (w_wl - w_ws) : (w_wl + w_ws);
        w_lz   = lzc49(w_sum);
        w_norm = w_sum << w_lz;
        w_eadd = {3'b0, w_el} + 11'sd1 - {5'b0, w_lz};
        if (w_na || w_nb)
            w_add = QNAN;
        else if (w_ia && w_ib)
            w_add = (w_sa != w_sbe) ? QNAN : {w_sa, 8'hFF, 23'd0};
        else if (w_ia)
            w_add = {w_sa, 8'hFF, 23'd0};
        else if (w_ib)
            w_add = {w_sbe, 8'hFF, 23'd0};
        else if (w_sum == 49'd0)
            w_add = 32'd0;
        else
            w_add = pack(w_sl, w_eadd, w_norm[47:25]);
    end

    logic              w_sx;
    logic [47:0]       w_prod;
    logic [22:0]       w_fmul;
    logic signed [10:0] w_emul;
    logic [31:0]       w_mul;

    always_comb begin
        w_sx   = w_sa ^ w_sb;
        w_prod = {24'd0, w_ma} * {24'd0, w_mb};
        w_fmul = w_prod[47] ? w_prod[46:24] : w_prod[45:23];
        w_emul = {3'b0, w_ea} + {3'b0, w_eb} - 11'sd127
               + {10'd0, w_prod[47]};
        if (w_na || w_nb)
            w_mul = QNAN;
        else if ((w_ia || w_ib) && (w_za || w_zb))
            w_mul = QNAN;
        else if (w_ia || w_ib)
            w_mul = {w_sx, 8'hFF, 23'd0};
        else if (w_za || w_zb)
            w_mul = {w_sx, 31'd0};
        else
            w_mul = pack(w_sx, w_emul, w_fmul);
    end

`ifdef FPU_DIV_EN
    logic [25:0]       w_rem, w_q;
    logic [22:0]       w_fdiv;
    logic signed [10:0] w_ediv;
    logic [31:0]       w_div;

    // Restoring array: w_q holds ma/mb scaled by 2^25.
    always_comb begin
        w_rem = {2'b0, w_ma};
        w_q   = '0;
        for (int i = 25; i >= 0; i--) begin
            if (i != 25) w_rem = {w_rem[24:0], 1'b0};
            if (w_rem >= {2'b0, w_mb}) begin
                w_q[i] = 1'b1;
                w_rem  = w_rem - {2'b0, w_mb};
            end
        end
        w_fdiv = w_q[25] ? w_q[24:2] : w_q[23:1];
        w_ediv = {3'b0, w_ea} - {3'b0, w_eb} + 11'sd126
               + {10'd0, w_q[25]};
        if (w_na || w_nb)
            w_div = QNAN;
        else if ((w_ia && w_ib) || (w_za && w_zb))
            w_div = QNAN;
        else if (w_ia)
            w_div = {w_sx, 8'hFF, 23'd0};
        else if (w_ib)
            w_div = {w_sx, 31'd0};
        else if (w_zb)
            w_div = {w_sx, 8'hFF, 23'd0};
        else if (w_za)
            w_div = {w_sx, 31'd0};
        else
            w_div = pack(w_sx, w_ediv, w_fdiv);
    end
`else
    logic [31:0] w_div;
    assign w_div = QNAN;
`endif

    always_comb begin
        unique case (r_op)
            2'b00:   w_res = w_add;
            2'b01:   w_res = w_add;
            2'b10:   w_res = w_div;
            default: w_res = w_mul;
        endcase
    end

endmodule

// File: tb/tb_fpu.sv
// Directed-vector bench for fpu: reset, pipeline timing and
// arithmetic/special cases with hand-computed results.
module tb_fpu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A, B, O;
    logic [1:0]  opcode;

    always #5 clk = ~clk;

    fpu dut (
        .clk(clk), .rst(rst), .A(A), .B(B),
        .opcode(opcode), .O(O)
    );

    localparam logic [31:0] NAN = 32'h7FC0_0000;
`ifdef FPU_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    logic [31:0] qa[$], qb[$], qe[$];
    logic [1:0]  qo[$];
    bit          qx[$];
    string       qt[$];

    task automatic vec(input string t, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] op,
                       input logic [31:0] e, input bit exact);
        qt.push_back(t);
        qa.push_back(a);
        qb.push_back(b);
        qo.push_back(op);
        qe.push_back(e);
        qx.push_back(exact);
    endtask

    // Divide results depend on whether the divider is built.
    function automatic logic [31:0] dv(input logic [31:0] e);
        return DIV_ON ? e : NAN;
    endfunction

    initial begin
        logic [31:0] m;
        int n;
        rst = 1'b1; A = '0; B = '0; opcode = 2'b00;
        @(negedge clk);
        A = 32'h3F80_0000; B = 32'h4000_0000;
        @(negedge clk);
        check("reset", O, 32'h0);

        rst = 1'b0;
        A = 32'h3F80_0000; B = 32'h4000_0000; opcode = 2'b00;
        @(negedge clk);
        A = 32'h4000_0000; B = 32'h4040_0000; opcode = 2'b11;
        @(negedge clk);
        check("pre_rst", O, 32'h4040_0000);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid", O, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_flush", O, 32'h0);
        @(negedge clk);
        check("rst_first", O, 32'h40C0_0000);

        vec("add_1_2",  32'h3F800000, 32'h40000000, 2'b00, 32'h40400000, 1);
        vec("sub_1_1",  32'h3F800000, 32'h3F800000, 2'b01, 32'h00000000, 1);
        vec("mul_2_3",  32'h40000000, 32'h40400000, 2'b11, 32'h40C00000, 1);
        vec("mul_ovf",  32'h7F000000, 32'h7F000000, 2'b11, 32'h7F800000, 1);
        vec("div_x_0",  32'h3F800000, 32'h00000000, 2'b10, dv(32'h7F800000), 1);
        vec("div_0_0",  32'h00000000, 32'h00000000, 2'b10, NAN, 1);
        vec("inf_ninf", 32'h7F800000, 32'hFF800000, 2'b00, NAN, 1);
        vec("div_v1",   32'hA972AB18, 32'h4E080232, 2'b10, dv(32'h9AE4611C), 0);
        vec("div_v2",   32'hCC1B821F, 32'hE31A3231, 2'b10, dv(32'h288116DC), 0);
        vec("sub_3_1",  32'h40400000, 32'h3F800000, 2'b01, 32'h40000000, 1);
        vec("add_3_m1", 32'h40400000, 32'hBF800000, 2'b00, 32'h40000000, 1);
        vec("add_1_m2", 32'h3F800000, 32'hC0000000, 2'b00, 32'hBF800000, 1);
        vec("mul_neg",  32'hC0000000, 32'h40400000, 2'b11, 32'hC0C00000, 1);
        vec("mul_0inf", 32'h00000000, 32'h7F800000, 2'b11, NAN, 1);
        vec("mul_nan",  32'h7FC00000, 32'h3F800000, 2'b11, NAN, 1);
        vec("mul_unf",  32'h00800000, 32'h00800000, 2'b11, 32'h00000000, 1);
        vec("add_sub",  32'h00400000, 32'h3F800000, 2'b00, 32'h3F800000, 1);
        vec("div_6_2",  32'h40C00000, 32'h40000000, 2'b10, dv(32'h40400000), 1);
        vec("div_1_3",  32'h3F800000, 32'h40400000, 2'b10, dv(32'h3EAAAAAA), 0);
        vec("div_xinf", 32'h3F800000, 32'h7F800000, 2'b10, dv(32'h00000000), 1);
        vec("add_inf",  32'h7F800000, 32'h3F800000, 2'b00, 32'h7F800000, 1);
        vec("add_ovf",  32'h7F7FFFFF, 32'h7F7FFFFF, 2'b00, 32'h7F800000, 1);
        vec("sub_nz",   32'hC0000000, 32'hC0000000, 2'b01, 32'h00000000, 1);
        vec("add_nan",  32'h3F800000, 32'h7FC00001, 2'b00, NAN, 1);

        // Back-to-back: vector k is checked two edges after it is driven.
        n = qa.size();
        for (int k = 0; k < n + 2; k++) begin
            if (k >= 2) begin
                m = qx[k-2] ? 32'hFFFF_FFFF : 32'hFFFF_F000;
                check(qt[k-2], O & m, qe[k-2] & m);
            end
            if (k < n) begin
                A = qa[k]; B = qb[k]; opcode = qo[k];
            end else begin
                A = '0; B = '0; opcode = 2'b00;
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
